adc_condition: RTL and testbench

//   Multi-channel ADC front-end conditioning, placed between the ADC input pins and the lock/demod DSP.
//   Per channel: converts inverted offset-binary ADC codes to two's complement, adds a signed offset with

---
 rtl/adc_condition.sv | 121 ++++++++++++
 tb/tb_adc_condition.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/adc_condition.sv
// Multi-channel ADC conditioning: offset-binary to two's complement, saturating offset,
// and power-of-two averaging/decimation with a shared frame counter and sticky overrange flags.
module adc_condition #(
    parameter int BITS         = 14,
    parameter int CHANNELS     = 2,
    parameter int DEC_LOG2_MAX = 4
) (
    input  logic                     clk,
    input  logic                     aresetn,
    input  logic [CHANNELS*BITS-1:0] adc_i,
    input  logic [CHANNELS*BITS-1:0] offset_i,
    input  logic [4:0]               dec_log2_i,
    input  logic                     flag_clr_i,
    output logic [CHANNELS*BITS-1:0] data_o,
    output logic                     valid_o,
    output logic [CHANNELS-1:0]      ovr_o
);
    localparam int AW = BITS + DEC_LOG2_MAX;
    localparam int CW = (DEC_LOG2_MAX > 0) ? DEC_LOG2_MAX : 1;
    localparam logic signed [BITS-1:0] S_MAX = {1'b0, {(BITS-1){1'b1}}};
    localparam logic signed [BITS-1:0] S_MIN = {1'b1, {(BITS-1){1'b0}}};

    logic          pv1_reg;
    logic          pv2_reg;
    logic          valid_reg;
    logic [CW-1:0] cnt_reg;
    logic [4:0]    k_reg;
    logic [4:0]    k_eff;
    logic          frame_end;

    // A new decimation exponent is only accepted at the start of a frame.
    always_comb begin
        k_eff = k_reg;
        if (cnt_reg == '0) begin
            k_eff = (dec_log2_i > 5'(DEC_LOG2_MAX)) ? 5'(DEC_LOG2_MAX) : dec_log2_i;
        end
        frame_end = (cnt_reg == CW'((32'd1 << k_eff) - 32'd1));
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            pv1_reg   <= 1'b0;
            pv2_reg   <= 1'b0;
            valid_reg <= 1'b0;
            cnt_reg   <= '0;
            k_reg     <= '0;
        end else begin
            pv1_reg   <= 1'b1;
            pv2_reg   <= pv1_reg;
            valid_reg <= 1'b0;
            if (pv2_reg) begin
                k_reg     <= k_eff;
                valid_reg <= frame_end;
                cnt_reg   <= frame_end ? '0 : cnt_reg + CW'(1);
            end
        end
    end

    assign valid_o = valid_reg;

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        logic        [BITS-1:0] adc;
        logic signed [BITS-1:0] offset;
        logic signed [BITS-1:0] conv_reg;
        logic signed [BITS-1:0] s2_reg;
        logic signed [BITS-1:0] s2_next;
        logic signed [BITS-1:0] data_reg;
        logic signed [BITS-1:0] data_next;
        logic signed [BITS:0]   sum;
        logic signed [AW-1:0]   acc_reg;
        logic signed [AW-1:0]   acc_sum;
        logic                   sat;
        logic                   ovr_event;
        logic                   ovr_reg;

        assign adc    = adc_i[gi*BITS +: BITS];
        assign offset = offset_i[gi*BITS +: BITS];

        always_comb begin
            sum     = (BITS+1)'(conv_reg) + (BITS+1)'(offset);
            sat     = (sum[BITS] != sum[BITS-1]);
            s2_next = sum[BITS-1:0];
            if (sat) begin
                s2_next = sum[BITS] ? S_MIN : S_MAX;
            end
            ovr_event = sat || (conv_reg == S_MIN) || (conv_reg == S_MAX);
            acc_sum   = acc_reg + AW'(s2_reg);
            // Arithmetic shift gives floor rounding for negative averages.
            data_next = BITS'(acc_sum >>> k_eff);
        end

        always_ff @(posedge clk or negedge aresetn) begin
            if (!aresetn) begin
                conv_reg <= '0;
                s2_reg   <= '0;
                acc_reg  <= '0;
                data_reg <= '0;
                ovr_reg  <= 1'b0;
            end else begin
                conv_reg <= {adc[BITS-1], ~adc[BITS-2:0]};
                s2_reg   <= s2_next;
                if (ovr_event) begin
                    ovr_reg <= 1'b1;
                end else if (flag_clr_i) begin
                    ovr_reg <= 1'b0;
                end
                if (pv2_reg) begin
                    if (frame_end) begin
                        data_reg <= data_next;
                        acc_reg  <= '0;
                    end else begin
                        acc_reg  <= acc_sum;
                    end
                end
            end
        end

        assign data_o[gi*BITS +: BITS] = data_reg;
        assign ovr_o[gi]               = ovr_reg;
    end
endmodule

// File: tb/tb_adc_condition.sv
// Directed bench for adc_condition: a sample-level model pushes expected averages into a
// scoreboard queue that is popped whenever the DUT strobes valid_o.
module tb_adc_condition;
    localparam int BITS = 14;
    localparam int CH   = 2;

    logic              clk = 1'b0;
    logic              aresetn = 1'b0;
    logic [CH*BITS-1:0] adc_i;
    logic [CH*BITS-1:0] offset_i;
    logic [4:0]        dec_log2_i;
    logic              flag_clr_i;
    logic [CH*BITS-1:0] data_o;
    logic              valid_o;
    logic [CH-1:0]     ovr_o;

    always #5 clk = ~clk;

    adc_condition #(.BITS(BITS), .CHANNELS(CH), .DEC_LOG2_MAX(4)) dut (
        .clk(clk),
        .aresetn(aresetn),
        .adc_i(adc_i),
        .offset_i(offset_i),
        .dec_log2_i(dec_log2_i),
        .flag_clr_i(flag_clr_i),
        .data_o(data_o),
        .valid_o(valid_o),
        .ovr_o(ovr_o)
    );

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    int m_conv[CH];
    int m_s2[CH];
    int m_acc[CH];
    int m_data[CH];
    bit m_ovr[CH];
    bit m_pv1, m_pv2, m_valid;
    int m_cnt, m_k;

    function automatic int to_s(input int v);
        int r;
        r = v & 16'h3FFF;
        if (r >= 8192) r = r - 16384;
        return r;
    endfunction

    // Code that the ADC would emit for a given two's-complement value.
    function automatic int enc(input int conv);
        return (conv & 16'h3FFF) ^ 16'h1FFF;
    endfunction

    function automatic int floor_div(input int s, input int n);
        int q;
        q = s / n;
        if ((s % n) != 0 && s < 0) q = q - 1;
        return q;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic set_in(input int a0, input int a1, input int o0, input int o1);
        adc_i[13:0]     = 14'(a0);
        adc_i[27:14]    = 14'(a1);
        offset_i[13:0]  = 14'(o0);
        offset_i[27:14] = 14'(o1);
    endtask

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_conv[c] = 0; m_s2[c] = 0; m_acc[c] = 0; m_data[c] = 0; m_ovr[c] = 0;
        end
        m_pv1 = 0; m_pv2 = 0; m_valid = 0; m_cnt = 0; m_k = 0;
        exp_q.delete();
    endtask

    task automatic model_edge();
        int conv_old, sum, adc_c, off_c;
        bit sat, ev;
        m_valid = 0;
        if (m_pv2) begin
            if (m_cnt == 0) m_k = (dec_log2_i > 4) ? 4 : int'(dec_log2_i);
            for (int c = 0; c < CH; c++) m_acc[c] += m_s2[c];
            if (m_cnt == (1 << m_k) - 1) begin
                for (int c = 0; c < CH; c++) begin
                    m_data[c] = floor_div(m_acc[c], 1 << m_k);
                    exp_q.push_back(m_data[c]);
                    m_acc[c] = 0;
                end
                m_cnt = 0;
                m_valid = 1;
            end else begin
                m_cnt++;
            end
        end
        for (int c = 0; c < CH; c++) begin
            off_c    = to_s(int'(offset_i[c*BITS +: BITS]));
            conv_old = m_conv[c];
            sum      = conv_old + off_c;
            sat      = (sum > 8191) || (sum < -8192);
            ev       = sat || conv_old == 8191 || conv_old == -8192;
            if (ev) m_ovr[c] = 1;
            else if (flag_clr_i) m_ovr[c] = 0;
            m_s2[c]  = (sum > 8191) ? 8191 : (sum < -8192) ? -8192 : sum;
        end
        m_pv2 = m_pv1;
        for (int c = 0; c < CH; c++) begin
            adc_c     = int'(adc_i[c*BITS +: BITS]);
            m_conv[c] = to_s(adc_c ^ 16'h1FFF);
        end
        m_pv1 = 1;
    endtask

    task automatic check_outputs();
        logic signed [31:0] d;
        check("valid", 32'(valid_o), 32'(m_valid));
        for (int c = 0; c < CH; c++) begin
            d = $signed(data_o[c*BITS +: BITS]);
            check("ovr", 32'(ovr_o[c]), 32'(m_ovr[c]));
            if (valid_o) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL scoreboard_empty observed %0d expected none", d);
                end else begin
                    check("data", d, exp_q.pop_front());
                end
            end else begin
                check("hold", d, m_data[c]);
            end
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            model_edge();
            #1;
            check_outputs();
        end
    endtask

    initial begin
        set_in(16'h1FFF, 16'h1FFF, 0, 0);
        dec_log2_i = 5'd0;
        flag_clr_i = 1'b0;
        model_reset();
        #12;
        check("rst_data", 32'(data_o), 32'd0);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_ovr", 32'(ovr_o), 32'd0);
        aresetn = 1'b1;

        // k=0 pass-through of zero, then positive saturation on channel 0
        step(6);
        set_in(16'h0001, enc(-300), 100, 0);
        step(4);
        set_in(16'h1FFF, 16'h1FFF, 0, 0);
        step(4);

        // k=2 averaging of 10,20,30,40 and -5..-8
        dec_log2_i = 5'd2;
        for (int r = 0; r < 4; r++) begin
            for (int i = 1; i <= 4; i++) begin
                set_in(enc(10 * i), enc(-4 - i), 0, 0);
                step(1);
            end
        end
        step(2);

        // k=1 floor rounding of negative averages, negative full scale on channel 1
        dec_log2_i = 5'd1;
        for (int r = 0; r < 3; r++) begin
            set_in(16'h2000, 16'h3FFF, 0, 0);
            step(1);
            set_in(16'h2001, 16'h3FFF, 0, 0);
            step(1);
        end
        set_in(16'h1FFF, 16'h1FFF, 0, 0);
        step(4);

        // flag clear racing an event on ch0, clearing a stale flag on ch1
        dec_log2_i = 5'd0;
        set_in(16'h0000, 16'h1FFF, 0, 0);
        step(3);
        flag_clr_i = 1'b1;
        step(1);
        flag_clr_i = 1'b0;
        set_in(16'h1FFF, 16'h1FFF, 0, 0);
        step(2);
        flag_clr_i = 1'b1;
        step(1);
        flag_clr_i = 1'b0;
        step(1);

        // k=3, reset in the middle of a frame
        dec_log2_i = 5'd3;
        for (int i = 0; i < 40 && !(m_k == 3 && m_cnt == 5); i++) begin
            set_in(enc(7 * i), enc(-3 * i), 0, 0);
            step(1);
        end
        check("reach_cnt5", m_cnt, 5);
        set_in(16'h0000, 16'h1FFF, 0, 0);
        step(1);
        #2;
        aresetn = 1'b0;
        #1;
        check("mid_rst_data", 32'(data_o), 32'd0);
        check("mid_rst_valid", 32'(valid_o), 32'd0);
        check("mid_rst_ovr", 32'(ovr_o), 32'd0);
        model_reset();
        #3;
        aresetn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) dec_log2_i = 5'd1;
            set_in(enc(11 * i - 50), enc(-9 * i + 13), 0, 0);
            step(1);
        end
        step(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
